// File: rtl/sd_grid_checker.sv
// Streaming Sudoku board checker: row/column/box legality plus the first offending cell.
// Latency: result strobe in the cycle after the edge that accepts the last cell.
// Backpressure: none; a cell is taken on every in_valid cycle except the result cycle.
module sd_grid_checker #(
    parameter  int BOX       = 3,
    parameter  int CELL_W    = 4,
    parameter  int SOLN_MODE = 0,
    localparam int N         = BOX * BOX,
    localparam int IDX_W     = $clog2(N * N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [CELL_W-1:0] in,
    output logic              out_valid,
    output logic              out_ok,
    output logic [1:0]        out_err_type,
    output logic [IDX_W-1:0]  out_err_idx,
    output logic [IDX_W:0]    out_blank_cnt
);
    localparam int RC_W  = $clog2(N);
    localparam int BC_W  = $clog2(BOX);
    localparam int CNT_W = IDX_W + 1;
    localparam int LAST  = N * N - 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_RANGE = 2'b01;
    localparam logic [1:0] ERR_BLANK = 2'b10;
    localparam logic [1:0] ERR_DUP   = 2'b11;

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic [RC_W-1:0]  row;
    logic [RC_W-1:0]  col;
    logic [BC_W-1:0]  row_in_box;
    logic [BC_W-1:0]  col_in_box;
    logic [BC_W-1:0]  box_r;
    logic [BC_W-1:0]  box_c;

    // bit v-1 of a mask is set once value v has been seen in that unit
    logic [N-1:0]     row_mask [N];
    logic [N-1:0]     col_mask [N];
    logic [N-1:0]     box_mask [N];

    logic [1:0]       err_type;
    logic [IDX_W-1:0] err_idx;
    logic [CNT_W-1:0] blank_cnt;

    logic             accept;
    logic             last_cell;
    logic [RC_W-1:0]  box;
    logic [N-1:0]     val_bit;
    logic             is_blank;
    logic             is_range;
    logic             is_dup;
    logic [1:0]       cell_err;
    logic [1:0]       nxt_err_type;
    logic [IDX_W-1:0] nxt_err_idx;
    logic [CNT_W-1:0] nxt_blank_cnt;

    // Classify the presented cell and fold its verdict into the running result
    always_comb begin
        accept    = in_valid && (state != DONE);
        last_cell = (idx == IDX_W'(LAST));
        box       = RC_W'(int'(box_r) * BOX + int'(box_c));
        is_blank  = (in == '0);
        is_range  = (int'(in) > N);
        val_bit   = '0;
        for (int v = 1; v <= N; v++) begin
            val_bit[v-1] = (int'(in) == v);
        end
        is_dup = |(val_bit & (row_mask[row] | col_mask[col] | box_mask[box]));

        cell_err = ERR_NONE;
        if (is_range) begin
            cell_err = ERR_RANGE;
        end else if (is_blank) begin
            if (SOLN_MODE != 0) begin
                cell_err = ERR_BLANK;
            end
        end else if (is_dup) begin
            cell_err = ERR_DUP;
        end

        // only the first error is kept; later cells still count blanks
        nxt_err_type = err_type;
        nxt_err_idx  = err_idx;
        if ((err_type == ERR_NONE) && (cell_err != ERR_NONE)) begin
            nxt_err_type = cell_err;
            nxt_err_idx  = idx;
        end
        nxt_blank_cnt = blank_cnt + CNT_W'(is_blank);
    end

    // FSM, incremental position counters, masks and result capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            idx           <= '0;
            row           <= '0;
            col           <= '0;
            row_in_box    <= '0;
            col_in_box    <= '0;
            box_r         <= '0;
            box_c         <= '0;
            err_type      <= ERR_NONE;
            err_idx       <= '0;
            blank_cnt     <= '0;
            out_valid     <= 1'b0;
            out_ok        <= 1'b0;
            out_err_type  <= ERR_NONE;
            out_err_idx   <= '0;
            out_blank_cnt <= '0;
            for (int i = 0; i < N; i++) begin
                row_mask[i] <= '0;
                col_mask[i] <= '0;
                box_mask[i] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE, LOAD: begin
                    if (accept) begin
                        state         <= LOAD;
                        // range errors and blanks leave val_bit empty, so masks stay put
                        row_mask[row] <= row_mask[row] | val_bit;
                        col_mask[col] <= col_mask[col] | val_bit;
                        box_mask[box] <= box_mask[box] | val_bit;
                        if (last_cell) begin
                            state         <= DONE;
                            out_valid     <= 1'b1;
                            out_ok        <= (nxt_err_type == ERR_NONE);
                            out_err_type  <= nxt_err_type;
                            out_err_idx   <= nxt_err_idx;
                            out_blank_cnt <= nxt_blank_cnt;
                            idx           <= '0;
                            row           <= '0;
                            col           <= '0;
                            row_in_box    <= '0;
                            col_in_box    <= '0;
                            box_r         <= '0;
                            box_c         <= '0;
                            err_type      <= ERR_NONE;
                            err_idx       <= '0;
                            blank_cnt     <= '0;
                        end else begin
                            err_type  <= nxt_err_type;
                            err_idx   <= nxt_err_idx;
                            blank_cnt <= nxt_blank_cnt;
                            idx       <= idx + IDX_W'(1);
                            if (col == RC_W'(N - 1)) begin
                                col        <= '0;
                                col_in_box <= '0;
                                box_c      <= '0;
                                row        <= row + RC_W'(1);
                                if (row_in_box == BC_W'(BOX - 1)) begin
                                    row_in_box <= '0;
                                    box_r      <= box_r + BC_W'(1);
                                end else begin
                                    row_in_box <= row_in_box + BC_W'(1);
                                end
                            end else begin
                                col <= col + RC_W'(1);
                                if (col_in_box == BC_W'(BOX - 1)) begin
                                    col_in_box <= '0;
                                    box_c      <= box_c + BC_W'(1);
                                end else begin
                                    col_in_box <= col_in_box + BC_W'(1);
                                end
                            end
                        end
                    end
                end
                DONE: begin
                    // result cycle: input is ignored, board storage wiped for the next one
                    state <= IDLE;
                    for (int i = 0; i < N; i++) begin
                        row_mask[i] <= '0;
                        col_mask[i] <= '0;
                        box_mask[i] <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_grid_checker.sv
// Bench for sd_grid_checker: 9x9 solution and puzzle checkers share one stream, 4x4 solution checker on its own.
// Expected results come from a divide/modulo reference model and are queued when a board is driven.
// Monitors on the falling edge pop and compare whenever a checker strobes its result.
module tb_sd_grid_checker;
    typedef int board_t [81];
    typedef struct {
        int ok;
        int et;
        int ei;
        int bc;
    } res_t;

    localparam int SOL [81] = '{
        5,3,4,6,7,8,9,1,2,
        6,7,2,1,9,5,3,4,8,
        1,9,8,3,4,2,5,6,7,
        8,5,9,7,6,1,4,2,3,
        4,2,6,8,5,3,7,9,1,
        7,1,3,9,2,4,8,5,6,
        9,6,1,5,3,7,2,8,4,
        2,8,7,4,1,9,6,3,5,
        3,4,5,2,8,6,1,7,9};

    localparam int PUZ [81] = '{
        5,3,0,0,7,0,0,0,0,
        6,0,0,1,9,5,0,0,0,
        0,9,8,0,0,0,0,6,0,
        8,0,0,0,6,0,0,0,3,
        4,0,0,8,0,3,0,0,1,
        7,0,0,0,2,0,0,0,6,
        0,6,0,0,0,0,2,8,0,
        0,0,0,4,1,9,0,0,5,
        0,0,0,0,8,0,0,7,9};

    localparam int SOL4 [16] = '{1,2,3,4, 3,4,1,2, 2,1,4,3, 4,3,2,1};
    localparam int DUP4 [16] = '{1,2,3,4, 3,1,4,2, 2,4,1,3, 4,3,2,1};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vld3;
    logic [3:0] din3;
    logic       vld2;
    logic [2:0] din2;

    logic       o3s_vld, o3s_ok, o3p_vld, o3p_ok, o2_vld, o2_ok;
    logic [1:0] o3s_et, o3p_et, o2_et;
    logic [6:0] o3s_ei, o3p_ei;
    logic [7:0] o3s_bc, o3p_bc;
    logic [3:0] o2_ei;
    logic [4:0] o2_bc;

    int     cyc   = 0;
    int     last3 = 0;
    int     last2 = 0;
    int     nvec  = 0;
    int     nerr  = 0;
    board_t bd3;
    board_t bd2;
    res_t   q3s[$];
    res_t   q3p[$];
    res_t   q2[$];

    sd_grid_checker #(.BOX(3), .CELL_W(4), .SOLN_MODE(1)) u_s3 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld3), .in(din3),
        .out_valid(o3s_vld), .out_ok(o3s_ok), .out_err_type(o3s_et),
        .out_err_idx(o3s_ei), .out_blank_cnt(o3s_bc));

    sd_grid_checker #(.BOX(3), .CELL_W(4), .SOLN_MODE(0)) u_p3 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld3), .in(din3),
        .out_valid(o3p_vld), .out_ok(o3p_ok), .out_err_type(o3p_et),
        .out_err_idx(o3p_ei), .out_blank_cnt(o3p_bc));

    sd_grid_checker #(.BOX(2), .CELL_W(3), .SOLN_MODE(1)) u_s2 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld2), .in(din2),
        .out_valid(o2_vld), .out_ok(o2_ok), .out_err_type(o2_et),
        .out_err_idx(o2_ei), .out_blank_cnt(o2_bc));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // reference: straightforward row/col/box bookkeeping with divide and modulo
    function automatic res_t model(input board_t b, input int box, input bit soln);
        int         n;
        int         r, c, bx, v, e;
        bit  [16:0] sr [16];
        bit  [16:0] sc [16];
        bit  [16:0] sb [16];
        res_t       res;
        n = box * box;
        for (int i = 0; i < 16; i++) begin
            sr[i] = '0; sc[i] = '0; sb[i] = '0;
        end
        res.et = 0; res.ei = 0; res.bc = 0;
        for (int i = 0; i < n * n; i++) begin
            r  = i / n;
            c  = i % n;
            bx = (r / box) * box + c / box;
            v  = b[i];
            e  = 0;
            if (v > n) begin
                e = 1;
            end else if (v == 0) begin
                res.bc++;
                if (soln) e = 2;
            end else begin
                if (sr[r][v] || sc[c][v] || sb[bx][v]) e = 3;
                sr[r][v] = 1'b1; sc[c][v] = 1'b1; sb[bx][v] = 1'b1;
            end
            if (res.et == 0 && e != 0) begin
                res.et = e;
                res.ei = i;
            end
        end
        res.ok = (res.et == 0) ? 1 : 0;
        return res;
    endfunction

    task automatic cmp_res(input string tg, input res_t e, input int ok, input int et,
                           input int ei, input int bc, input int last);
        chk({tg, " ok"}, ok, e.ok);
        chk({tg, " err_type"}, et, e.et);
        chk({tg, " err_idx"}, ei, e.ei);
        chk({tg, " blank_cnt"}, bc, e.bc);
        chk({tg, " result latency"}, cyc, last);
    endtask

    always @(negedge clk) begin
        if (o3s_vld) begin
            if (q3s.size() == 0) chk("s3 unexpected out_valid", int'(o3s_vld), 0);
            else cmp_res("s3", q3s.pop_front(), int'(o3s_ok), int'(o3s_et), int'(o3s_ei), int'(o3s_bc), last3);
        end
    end

    always @(negedge clk) begin
        if (o3p_vld) begin
            if (q3p.size() == 0) chk("p3 unexpected out_valid", int'(o3p_vld), 0);
            else cmp_res("p3", q3p.pop_front(), int'(o3p_ok), int'(o3p_et), int'(o3p_ei), int'(o3p_bc), last3);
        end
    end

    always @(negedge clk) begin
        if (o2_vld) begin
            if (q2.size() == 0) chk("s2 unexpected out_valid", int'(o2_vld), 0);
            else cmp_res("s2", q2.pop_front(), int'(o2_ok), int'(o2_et), int'(o2_ei), int'(o2_bc), last2);
        end
    end

    task automatic push3();
        q3s.push_back(model(bd3, 3, 1'b1));
        q3p.push_back(model(bd3, 3, 1'b0));
    endtask

    task automatic push2();
        q2.push_back(model(bd2, 2, 1'b1));
    endtask

    // leaves in_valid high on the last cell; callers decide what follows
    task automatic send3(input bit gaps);
        for (int i = 0; i < 81; i++) begin
            vld3 = 1'b1;
            din3 = 4'(bd3[i]);
            @(posedge clk); #1;
            if (i == 80) last3 = cyc;
            else if (gaps) begin
                vld3 = 1'b0;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic send2(input bit gaps);
        for (int i = 0; i < 16; i++) begin
            vld2 = 1'b1;
            din2 = 3'(bd2[i]);
            @(posedge clk); #1;
            if (i == 15) last2 = cyc;
            else if (gaps) begin
                vld2 = 1'b0;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic idle(input int n);
        vld3 = 1'b0;
        vld2 = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic rst_chk(input string tg);
        chk({tg, " s3 out_valid"}, int'(o3s_vld), 0);
        chk({tg, " s3 out_ok"}, int'(o3s_ok), 0);
        chk({tg, " s3 err_type"}, int'(o3s_et), 0);
        chk({tg, " s3 err_idx"}, int'(o3s_ei), 0);
        chk({tg, " p3 out_ok"}, int'(o3p_ok), 0);
        chk({tg, " p3 blank_cnt"}, int'(o3p_bc), 0);
        chk({tg, " s2 out_valid"}, int'(o2_vld), 0);
        chk({tg, " s2 blank_cnt"}, int'(o2_bc), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        vld3  = 1'b0;
        din3  = '0;
        vld2  = 1'b0;
        din2  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_chk("por");
        rst_n = 1'b1;
        idle(2);

        // solved grid, continuous stream
        bd3 = SOL;
        push3(); send3(1'b0); idle(3);

        // same row duplicate at 40, second corruption at 70 must not override
        bd3 = SOL; bd3[40] = bd3[36]; bd3[70] = 4;
        push3(); send3(1'b0); idle(3);

        // puzzle with 51 blanks, in_valid toggling
        bd3 = PUZ;
        push3(); send3(1'b1); idle(3);

        // out-of-range at 5, later duplicate at 20
        bd3 = SOL; bd3[5] = 10; bd3[20] = bd3[19];
        push3(); send3(1'b1); idle(3);

        // all blanks
        for (int i = 0; i < 81; i++) bd3[i] = 0;
        push3(); send3(1'b0); idle(3);

        // abort after 30 cells with a one-cycle reset, then a fresh board
        bd3 = PUZ;
        for (int i = 0; i < 30; i++) begin
            vld3 = 1'b1;
            din3 = 4'(bd3[i]);
            @(posedge clk); #1;
        end
        vld3  = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_chk("midboard reset");
        rst_n = 1'b1;
        bd3 = SOL;
        push3(); send3(1'b0);

        // in_valid stays high through the result cycle with the next board's first cell
        bd3 = SOL;
        push3();
        din3 = 4'(bd3[0]);
        @(posedge clk); #1;
        send3(1'b0); idle(3);

        // 4x4 boards: legal, box-only duplicate, then a few random ones
        for (int i = 0; i < 81; i++) bd2[i] = 0;
        for (int i = 0; i < 16; i++) bd2[i] = SOL4[i];
        push2(); send2(1'b0); idle(2);
        for (int i = 0; i < 16; i++) bd2[i] = DUP4[i];
        push2(); send2(1'b1); idle(2);
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 16; i++) bd2[i] = int'($urandom_range(0, 5));
            push2(); send2(k[0]); idle(2);
        end

        for (int k = 0; k < 50 && (q3s.size() + q3p.size() + q2.size()) != 0; k++) begin
            @(posedge clk); #1;
        end
        chk("results outstanding", q3s.size() + q3p.size() + q2.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/sd_grid_checker.md
Name: sd_grid_checker

Overview:
- Streaming Sudoku board checker: accepts an N x N board one cell per accepted cycle, in row-major order, on the same in_valid/in handshake the SD solver uses.
- Reports in one result pulse whether the board obeys row, column and box constraints, plus the first offending cell.
- Parametrised in box size (N = BOX*BOX) and mode: puzzle check (blanks allowed) or solution check (blanks illegal).
- Sits in front of / behind the SD solver for input screening and self-checking of solver output.

Parameters:
- BOX, 3, box edge; N = BOX*BOX; legal 2..4.
- CELL_W, 4, cell value width; must satisfy 2^CELL_W > N.
- SOLN_MODE, 0, 0 = puzzle check (value 0 = blank, legal); 1 = solution check (value 0 is an error).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  cell qualifier
- in  in  CELL_W  cell value, 0 = blank
- out_valid  out  1  one-cycle result strobe
- out_ok  out  1  1 = board legal; qualified by out_valid
- out_err_type  out  2  00 none, 01 out of range (value > N), 10 blank in SOLN_MODE, 11 duplicate
- out_err_idx  out  IDX_W  row-major index of first error cell; IDX_W = clog2(N*N); 0 when no error
- out_blank_cnt  out  IDX_W+1  number of blank cells in the board

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE, all counters/masks cleared; out_valid=0, out_ok=0, out_err_type=0, out_err_idx=0, out_blank_cnt=0. Reset is honoured mid-board: partial board discarded, no out_valid.
- Storage: row_mask[N], col_mask[N], box_mask[N], each N bits (bit v-1 = value v seen). Row, column, box-row and box-column counters are kept incrementally; no divide/modulo. Box index b = box_r*BOX + box_c.
- FSM states:
  - IDLE: first in_valid goes to LOAD and processes that cell in the same cycle.
  - LOAD: each in_valid=1 cycle accepts one cell. in_valid=0 pauses with all counters held; gaps are unlimited.
  - DONE: entered after cell N*N-1 is accepted. Asserts out_valid for exactly one cycle (latency = 1 cycle after the last cell edge), clears masks/counters, returns to IDLE.
- in_valid during the DONE cycle is ignored; no cell is consumed.
- Per accepted cell v at (r,c,b), checks in priority order:
  - v > N: range error; masks not updated.
  - v == 0: blank_cnt++. If SOLN_MODE=1, blank error.
  - Otherwise, if row_mask[r][v], col_mask[c][v] or box_mask[b][v] is set: duplicate error. Mask bits are set (idempotent).
- Only the first error is latched: err_type and err_idx freeze; later cells are still consumed and counted.
- Result outputs change only in the DONE cycle and hold their value until the next DONE cycle or reset. out_valid is low otherwise.
- out_ok = (err_type == 00).
- Full board of blanks in puzzle mode is legal: out_ok=1, out_blank_cnt=N*N.

Test Plan:
- BOX=3, SOLN_MODE=1, valid solved grid (first row 5,3,4,6,7,8,9,1,2 ...), in_valid continuous 81 cycles -> out_valid exactly 1 cycle after cell 80; out_ok=1, out_err_type=00, out_err_idx=0, out_blank_cnt=0.
- Same grid with cell 40 changed to equal cell 36 (same row) and cell 70 also corrupted -> out_ok=0, out_err_type=11, out_err_idx=40 (first error only).
- BOX=3, SOLN_MODE=0, puzzle with 51 blanks, in_valid toggling 1/0 every cycle -> out_valid 1 cycle after the 81st accepted cell; out_ok=1, out_blank_cnt=51. Same board with SOLN_MODE=1 -> out_err_type=10 at the first blank index.
- Cell 5 = 10 (value > N) -> out_err_type=01, out_err_idx=5; a later duplicate at cell 20 does not override.
- rst_n low for 1 cycle after 30 cells, then a full valid board -> no out_valid for the aborted board; result matches the fresh board only. in_valid held high through the DONE cycle -> that cycle's cell is not consumed; next board starts on the following cycle.
- BOX=2 (N=4, CELL_W=3), 4x4 solution with box-only duplicate (cells 0 and 5 both 1) -> out_err_type=11, out_err_idx=5.
